dmem_lane_responder: RTL and testbench
======================================

# dmem_lane_responder

Memory-side responder for the data-memory port. It accepts one access at a time from the store/load control path: address, raw store data and an active-low byte-lane write mask. It commits writes lane by lane after a configurable number of wait states. For reads, it returns the addressed bytes right-justified so the load-extension stage can sign- or zero-extend from bit 7, 15 or 31.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- WAIT_STATES, 1: extra busy cycles per access, 0..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  1  access request; sampled only while ready_o=1.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, already lane-positioned by the requester.
- wen_n_i  in  4  active-low lane write mask (bit k=0 writes byte k). 4'b1111 is a read. 4'b0000 is a full-word write.
- ready_o  out  1  responder can accept a request this cycle.
- done_o  out  1  one-cycle pulse when an access completes.
- rdata_o  out  32  right-justified read data; valid with done_o and held until the next done_o.
- err_o  out  1  out-of-range access; valid with done_o.

## Operation
- Transfer: a request is accepted on a rising edge where req_i=1 and ready_o=1.
- Captured at acceptance: addr_i, wdata_i and wen_n_i into internal registers. Later input changes are ignored.
- Access type: wen_n_i != 4'b1111 is a write; 4'b1111 is a read.
- Word index: addr[log2(DEPTH_WORDS)+1:2].
- Write: at completion, byte k of the indexed word takes wdata[8k+7:8k] for every k where wen_n[k]=0. Other bytes are unchanged.
- Read: word is shifted right by 8*addr[1:0], zero-filled from the top.
  - addr[1:0]=01 gives {8'h0, word[31:8]}.
  - Write accesses leave rdata_o unchanged.
- State machine:
  - IDLE (ready_o=1): on accept, go to BUSY with counter=WAIT_STATES. If WAIT_STATES=0, perform the access at the same edge and stay in IDLE.
  - BUSY (ready_o=0): counter decrements each cycle. At the edge where counter==1, perform the access and return to IDLE.
- done_o is registered. It is high in the first IDLE cycle after the access is performed.
- Back-to-back: a new request may be accepted in the same cycle that done_o is high.
- Alignment is not checked. Misaligned halfword/word accesses use the mask as given and the shift rule above.
- Memory contents are not reset.

## Timing
- Latency: done_o rises exactly WAIT_STATES+1 cycles after the accepting edge.
- Throughput: one access per WAIT_STATES+1 cycles.
- Reset values: ready_o=1, done_o=0, rdata_o=32'h0, err_o=0, state IDLE, counter 0.
- Reset asserted mid-access: the access is aborted, no write is committed, and done_o is not produced after reset release.
- A write followed immediately by a read of the same word returns the updated bytes.
- req_i held high while ready_o=0 has no effect.

## Configuration
- DMEM_BOUNDS_CHECK_EN defined:
  - An access with word address ≥ DEPTH_WORDS, or with addr_i bits above the index nonzero, completes with normal latency and err_o=1.
  - Its write is suppressed; its rdata_o is 32'h0.
- DMEM_BOUNDS_CHECK_EN undefined: the index wraps modulo DEPTH_WORDS, upper address bits are ignored, and err_o is tied to 0.

## Structure
- Shared package holds:
  - the typedef for the 4-bit active-low lane mask;
  - constants LANE_MASK_NONE=4'b1111 and LANE_MASK_WORD=4'b0000;
  - the state enum {IDLE, BUSY}.
- One sub-module, dmem_lane_array: a byte-lane-writable storage array with one write port and one read port. The FSM, counter, capture registers and read shifter stay in the top module.

## Test plan
- Reset: rst_ni low for 3 cycles, then high → ready_o=1, done_o=0, rdata_o=0, err_o=0.
- Full-word write then read (WAIT_STATES=1): write 32'hDEADBEEF to addr 0x10 with mask 4'b0000, then read addr 0x10 with mask 4'b1111 → each done_o arrives 2 cycles after accept; rdata_o=32'hDEADBEEF.
- Byte-lane write: write 32'h00AB0000 to addr 0x12 with mask 4'b1011, then read word 0x10 → rdata_o=32'hDEABBEEF; read addr 0x12 → rdata_o=32'h0000DEAB.
- Back-to-back accesses: req_i held high for 3 different accesses (WAIT_STATES=0) → 3 consecutive done_o pulses, one per cycle, with no gaps.
- Abort: rst_ni pulsed low during BUSY of a write of 32'h11111111 to 0x20 → no done_o after release; a later read of 0x20 returns the prior contents.
- Out of range (macro defined, DEPTH_WORDS=1024): write to 0x1000 → done_o with err_o=1 and array unchanged. Without the macro, the same write lands in word 0.

Source files
------------

// File: rtl/dmem_lane_responder_pkg.sv
// Shared types and constants for the data-memory lane responder.
package dmem_lane_responder_pkg;

  // Active-low byte-lane write mask: bit k = 0 writes byte k.
  typedef logic [3:0] lane_mask_t;

  localparam lane_mask_t LANE_MASK_NONE = 4'b1111;  // read
  localparam lane_mask_t LANE_MASK_WORD = 4'b0000;  // full-word write

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

endpackage

// File: rtl/dmem_lane_array.sv
// Byte-lane-writable word array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module dmem_lane_array
  import dmem_lane_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IdxW        = $clog2(DEPTH_WORDS)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  lane_mask_t      wen_n_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Commit only the lanes whose mask bit is low.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (!wen_n_i[k]) begin
          mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_lane_responder.sv
// Data-memory responder: one access at a time, WAIT_STATES busy cycles, right-justified reads.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag out-of-range accesses on err_o.
module dmem_lane_responder
  import dmem_lane_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  lane_mask_t  wen_n_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);
  localparam bit          ZeroWait = (WAIT_STATES == 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  lane_mask_t  wen_n_q;
  logic        done_q, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic            accept, perform;
  logic [31:0]     acc_addr, acc_wdata, word_rd;
  lane_mask_t      acc_wen_n;
  logic [IdxW-1:0] acc_idx;
  logic            acc_write, acc_oob;

  assign accept = req_i && (state_q == StIdle);

  // With no wait states the access happens at the accepting edge, straight from the inputs.
  assign acc_addr  = ZeroWait ? addr_i  : addr_q;
  assign acc_wdata = ZeroWait ? wdata_i : wdata_q;
  assign acc_wen_n = ZeroWait ? wen_n_i : wen_n_q;
  assign acc_idx   = acc_addr[IdxW+1:2];
  assign acc_write = (acc_wen_n != LANE_MASK_NONE);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign acc_oob = |acc_addr[31:IdxW+2];
`else
  // Upper bits are ignored: the index wraps modulo DEPTH_WORDS.
  logic unused_upper_addr;
  assign unused_upper_addr = ^acc_addr[31:IdxW+2];
  assign acc_oob = 1'b0;
`endif

  dmem_lane_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (perform && acc_write && !acc_oob),
    .waddr_i(acc_idx),
    .wdata_i(acc_wdata),
    .wen_n_i(acc_wen_n),
    .raddr_i(acc_idx),
    .rdata_o(word_rd)
  );

  // Next state, wait counter and the access strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perform = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ZeroWait) begin
            perform = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = WaitInit;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          perform = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read result and error flag update only when an access is performed.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (perform) begin
      err_d = acc_oob;
      if (!acc_write) begin
        rdata_d = acc_oob ? 32'h0 : (word_rd >> {acc_addr[1:0], 3'b000});
      end
    end
  end

  // State, capture and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wen_n_q <= LANE_MASK_NONE;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        wen_n_q <= wen_n_i;
      end
      done_q  <= perform;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_lane_responder.sv
// Bench for dmem_lane_responder: directed table, back-to-back, abort, range and random accesses.
module tb_dmem_lane_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req = 1'b0, req0 = 1'b0;
  logic [31:0] addr = '0, addr0 = '0, wdata = '0, wdata0 = '0;
  logic [3:0]  wen_n = 4'hF, wen_n0 = 4'hF;
  logic        ready, done, err, ready0, done0, err0;
  logic [31:0] rdata, rdata0;

  int n_pass = 0;
  int n_total = 0;

  // Byte-addressed reference memory and last read result for the WAIT_STATES=1 instance.
  logic [7:0]  mem_b [DEPTH*4];
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_lane_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .wdata_i(wdata),
    .wen_n_i(wen_n), .ready_o(ready), .done_o(done), .rdata_o(rdata), .err_o(err)
  );

  dmem_lane_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .addr_i(addr0), .wdata_i(wdata0),
    .wen_n_i(wen_n0), .ready_o(ready0), .done_o(done0), .rdata_o(rdata0), .err_o(err0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic bit model_oob(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return a >= DEPTH * 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned base_of(input logic [31:0] a);
    return ((a / 4) % DEPTH) * 4;
  endfunction

  // Bytes from the addressed offset up to the top of the word, zero-filled above.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r = 32'h0;
    int unsigned off = a % 4;
    for (int j = 0; j < 4; j++) begin
      if (off + j < 4) r[8*j +: 8] = mem_b[base_of(a) + off + j];
    end
    return r;
  endfunction

  // One access on the WAIT_STATES=1 instance; starts and ends at a falling edge.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wn,
                           input string nm);
    int lat;
    bit oob = model_oob(a);
    check({nm, " ready"}, {31'h0, ready}, 32'h1);
    req = 1'b1; addr = a; wdata = wd; wen_n = wn;
    @(posedge clk); #1;
    // Later input changes must be ignored.
    req = 1'b0; addr = $urandom; wdata = $urandom; wen_n = 4'($urandom);
    check({nm, " busy"}, {31'h0, ready}, 32'h0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    check({nm, " latency"}, lat, 2);
    check({nm, " err"}, {31'h0, err}, {31'h0, oob});
    if (wn == 4'hF) last_rdata = oob ? 32'h0 : model_read(a);
    else if (!oob) begin
      for (int k = 0; k < 4; k++) if (!wn[k]) mem_b[base_of(a) + k] = wd[8*k +: 8];
    end
    check({nm, " rdata"}, rdata, last_rdata);
    @(negedge clk);
    check({nm, " pulse"}, {31'h0, done}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen_n;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs[9];
    logic [31:0] w0;
    int seen;

    vecs[0] = '{32'h10, 32'hDEADBEEF, 4'b0000, 32'h0};
    vecs[1] = '{32'h10, 32'h0,        4'b1111, 32'hDEADBEEF};
    vecs[2] = '{32'h12, 32'h00AB0000, 4'b1011, 32'h0};
    vecs[3] = '{32'h10, 32'h0,        4'b1111, 32'hDEABBEEF};
    vecs[4] = '{32'h12, 32'h0,        4'b1111, 32'h0000DEAB};
    vecs[5] = '{32'h11, 32'h0,        4'b1111, 32'h00DEABBE};
    vecs[6] = '{32'h13, 32'h0,        4'b1111, 32'h000000DE};
    vecs[7] = '{32'h20, 32'hCAFEF00D, 4'b0000, 32'h0};
    vecs[8] = '{32'h20, 32'h0,        4'b1111, 32'hCAFEF00D};

    // Reset.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset ready", {31'h0, ready}, 32'h1);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset err", {31'h0, err}, 32'h0);
    check("reset ready0", {31'h0, ready0}, 32'h1);

    // Directed table.
    foreach (vecs[i]) begin
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].wen_n, $sformatf("vec%0d", i));
      if (vecs[i].wen_n == 4'hF) check($sformatf("vec%0d table", i), rdata, vecs[i].exp_rdata);
    end

    // Back-to-back on the zero-wait instance: one done per cycle.
    req0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h12345678; wen_n0 = 4'b0000;
    @(negedge clk);
    check("b2b done1", {31'h0, done0}, 32'h1);
    addr0 = 32'h41; wdata0 = 32'h0000AA00; wen_n0 = 4'b1101;
    @(negedge clk);
    check("b2b done2", {31'h0, done0}, 32'h1);
    check("b2b ready", {31'h0, ready0}, 32'h1);
    addr0 = 32'h41; wdata0 = 32'h0; wen_n0 = 4'b1111;
    @(negedge clk);
    check("b2b done3", {31'h0, done0}, 32'h1);
    check("b2b rdata", rdata0, 32'h001234AA);
    check("b2b err", {31'h0, err0}, 32'h0);
    req0 = 1'b0;
    @(negedge clk);
    check("b2b idle", {31'h0, done0}, 32'h0);

    // Abort a write with reset while busy.
    req = 1'b1; addr = 32'h20; wdata = 32'h11111111; wen_n = 4'b0000;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no done", seen, 0);
    check("abort ready", {31'h0, ready}, 32'h1);
    check("abort rdata", rdata, 32'h0);
    do_access(32'h20, 32'h0, 4'b1111, "abort read");
    check("abort prior", rdata, 32'hCAFEF00D);

    // Initialise words 0..7 so later reads are defined.
    for (int i = 0; i < 8; i++) do_access(i * 4, $urandom, 4'b0000, $sformatf("init%0d", i));

    // Out-of-range write.
    w0 = model_read(32'h0);
    do_access(32'h1000, 32'h55667788, 4'b0000, "oob write");
`ifdef DMEM_BOUNDS_CHECK_EN
    check("oob err", {31'h0, err}, 32'h1);
`else
    check("oob err", {31'h0, err}, 32'h0);
`endif
    do_access(32'h0, 32'h0, 4'b1111, "oob word0");
`ifdef DMEM_BOUNDS_CHECK_EN
    check("oob word0 value", rdata, w0);
`else
    check("oob word0 value", rdata, 32'h55667788);
`endif

    // Random accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [3:0]  wn;
      int unsigned r;
      a = $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r == 0) a = a | 32'h1000;
      else if (r == 1) a = a | 32'h8000_0000;
      wn = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      do_access(a, $urandom, wn, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
